// File: rtl/mc_control_fsm.sv
// Main control FSM of the RV32I multicycle core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and memory handshake.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALRADR,
        S_JAL,
        S_LUI
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_d;
    logic       take;

    logic       mem_req_q, mem_req_d;
    logic       mem_write_q, mem_write_d;
    logic       adr_src_q, adr_src_d;
    logic       reg_write_q, reg_write_d;
    logic       pc_write_q, pc_write_d;
    logic [1:0] alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] result_src_q, result_src_d;
    logic [1:0] alu_op_q, alu_op_d;

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = alu_zero;
            3'b001:  take = ~alu_zero;
            3'b100:  take = alu_lt;
            3'b101:  take = ~alu_lt;
            3'b110:  take = alu_ltu;
            3'b111:  take = ~alu_ltu;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALRADR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALRADR:  state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_write_d  = 1'b0;
        adr_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        pc_write_d   = 1'b0;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        result_src_d = 2'b00;
        alu_op_d     = 2'b00;
        case (state_d)
            S_FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            S_MEMADR, S_JALRADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                adr_src_d   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op_d    = 2'b10;
            end
            S_ALUWB:  reg_write_d = 1'b1;
            S_BRANCH: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b01;
            end
            S_JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_write_d  = 1'b1;
            end
            S_LUI: begin
                alu_src_a_d = 2'b11;
                alu_src_b_d = 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            adr_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            pc_write_q   <= 1'b0;
            alu_src_a_q  <= '0;
            alu_src_b_q  <= '0;
            result_src_q <= '0;
            alu_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            adr_src_q    <= adr_src_d;
            reg_write_q  <= reg_write_d;
            pc_write_q   <= pc_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            result_src_q <= result_src_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // Handshake- and condition-dependent strobes must react within the same cycle.
    assign ir_write   = (state_q == S_FETCH) && mem_ready;
    assign pc_write   = pc_write_q || ir_write || ((state_q == S_BRANCH) && take);
    assign illegal_op = (state_q == S_DECODE) && illegal_d;

    assign mem_req    = mem_req_q;
    assign mem_write  = mem_write_q;
    assign adr_src    = adr_src_q;
    assign reg_write  = reg_write_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign result_src = result_src_q;
    assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected output traces compared every cycle,
// plus literal instruction-length and pulse-count pins.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_op;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z, lt, ltu;
        logic [14:0] exp;
    } rec_t;

    rec_t q[$];
    int   irq[$];
    int   passed = 0, total = 0;
    int   idle_cyc = 0, ill_cnt = 0;

    logic       cur_rst = 1'b1;
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    logic       cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0;

    // Vector layout: req wr adr ir pc rw a[2] b[2] rs[2] op[2] ill
    function automatic logic [14:0] ov(input logic req, wr, adr, ir, pc, rw,
                                       input logic [1:0] a, b, rs, aop, input logic ill);
        return {req, wr, adr, ir, pc, rw, a, b, rs, aop, ill};
    endfunction

    function automatic logic br_take(input logic [2:0] f3, input logic z, lt, ltu);
        logic c;
        if (f3[2:1] == 2'b01) return 1'b0;
        c = f3[2] ? (f3[1] ? ltu : lt) : z;
        return c ^ f3[0];
    endfunction

    task automatic push(input logic mr, input logic [14:0] e);
        rec_t r;
        r.rst = cur_rst; r.mr = mr; r.op = cur_op; r.f3 = cur_f3;
        r.z = cur_z; r.lt = cur_lt; r.ltu = cur_ltu; r.exp = e;
        q.push_back(r);
    endtask

    function automatic logic any_mr();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch(input int w);
        for (int i = 0; i < w; i++) push(1'b0, ov(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
        push(1'b1, ov(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    endtask

    task automatic memacc(input int w, input logic wr);
        for (int i = 0; i < w; i++) push(1'b0, ov(1,wr,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        push(1'b1, ov(1,wr,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    endtask

    task automatic decode_step();
        logic legal;
        legal = cur_op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        push(any_mr(), ov(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, !legal));
    endtask

    task automatic wb();
        push(any_mr(), ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    endtask

    task automatic jal_step();
        push(any_mr(), ov(0,0,0,0,1,0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
    endtask

    task automatic memadr();
        push(any_mr(), ov(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z, lt, ltu,
                         input int fw, input int mw);
        cur_op = op; cur_f3 = f3; cur_z = z; cur_lt = lt; cur_ltu = ltu;
        fetch(fw);
        decode_step();
        case (op)
            7'b0000011: begin memadr(); memacc(mw, 1'b0);
                push(any_mr(), ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 2'b00, 0)); end
            7'b0100011: begin memadr(); memacc(mw, 1'b1); end
            7'b0110011: begin push(any_mr(), ov(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 2'b10, 0)); wb(); end
            7'b0010011: begin push(any_mr(), ov(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b10, 0)); wb(); end
            7'b1100011: push(any_mr(), ov(0,0,0,0,br_take(f3, z, lt, ltu),0, 2'b10, 2'b00, 2'b00, 2'b01, 0));
            7'b1101111: begin jal_step(); wb(); end
            7'b1100111: begin memadr(); jal_step(); wb(); end
            7'b0110111: begin push(any_mr(), ov(0,0,0,0,0,0, 2'b11, 2'b01, 2'b00, 2'b00, 0)); wb(); end
            7'b0010111: wb();
            default: ;
        endcase
    endtask

    // Store whose memory wait is cut short by reset; the abandoned access must vanish.
    task automatic store_reset();
        cur_op = 7'b0100011; cur_f3 = 3'b010;
        fetch(0);
        decode_step();
        memadr();
        push(1'b0, ov(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        cur_rst = 1'b0;
        push(1'b0, ov(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        push(1'b0, '0);
        cur_rst = 1'b1;
        push(1'b1, '0);
    endtask

    task automatic pin(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        cur_rst = 1'b0;
        push(1'b1, '0);
        push(1'b1, '0);
        cur_rst = 1'b1;
        idle_cyc = q.size();
        push(1'b1, '0);
        instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0);  // add
        instr(7'b0000011, 3'b010, 0, 0, 0, 0, 3);  // lw, 3 wait cycles
        instr(7'b1100011, 3'b000, 1, 0, 0, 0, 0);  // beq taken
        instr(7'b1100011, 3'b000, 0, 0, 0, 0, 0);  // beq not taken
        instr(7'b1100011, 3'b110, 0, 0, 1, 0, 0);  // bltu taken
        instr(7'b1100111, 3'b000, 0, 0, 0, 0, 0);  // jalr
        instr(7'b0000000, 3'b000, 0, 0, 0, 0, 0);  // illegal
        instr(7'b0110111, 3'b000, 0, 0, 0, 1, 0);  // lui, fetch wait 1
        instr(7'b0010111, 3'b000, 0, 0, 0, 0, 0);  // auipc
        instr(7'b0100011, 3'b010, 0, 0, 0, 0, 0);  // sw
        instr(7'b1101111, 3'b000, 0, 0, 0, 0, 0);  // jal
        instr(7'b0010011, 3'b000, 0, 0, 0, 2, 0);  // addi, fetch wait 2
        instr(7'b1100011, 3'b001, 0, 0, 0, 0, 0);  // bne taken
        instr(7'b1100011, 3'b100, 0, 0, 0, 0, 0);  // blt not taken
        instr(7'b1100011, 3'b101, 0, 0, 0, 0, 0);  // bge taken
        instr(7'b1100011, 3'b111, 0, 0, 0, 0, 0);  // bgeu taken
        instr(7'b1100011, 3'b010, 1, 1, 1, 0, 0);  // reserved funct3, never taken
        instr(7'b0100011, 3'b010, 0, 0, 0, 0, 2);  // sw, 2 wait cycles
        store_reset();
        instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < q.size(); i++) begin
            logic [14:0] act;
            #1;
            rst_n = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op; funct3 = q[i].f3;
            alu_zero = q[i].z; alu_lt = q[i].lt; alu_ltu = q[i].ltu;
            @(negedge clk);
            act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, illegal_op};
            total++;
            if (act === q[i].exp) passed++;
            else $display("FAIL cycle%0d outputs: got %b, expected %b (req wr adr ir pc rw a b rs op ill)",
                          i, act, q[i].exp);
            if (ir_write === 1'b1) irq.push_back(i);
            if (illegal_op === 1'b1) ill_cnt++;
            @(posedge clk);
        end

        pin("illegal_pulses", ill_cnt, 1);
        pin("fetch_count_ge8", (irq.size() >= 8) ? 1 : 0, 1);
        if (irq.size() >= 8) begin
            pin("reset_to_first_fetch", irq[0] - idle_cyc, 1);
            pin("reset_to_second_fetch", irq[1] - idle_cyc, 5);
            pin("add_cycles", irq[1] - irq[0], 4);
            pin("lw_wait3_cycles", irq[2] - irq[1], 8);
            pin("beq_taken_cycles", irq[3] - irq[2], 3);
            pin("beq_not_taken_cycles", irq[4] - irq[3], 3);
            pin("bltu_cycles", irq[5] - irq[4], 3);
            pin("jalr_cycles", irq[6] - irq[5], 5);
            pin("illegal_plus_fetchwait", irq[7] - irq[6], 3);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
